dlx_pipeline: RTL and testbench
===============================

// Module: dlx_pipeline
// PURPOSE
//  Five-stage (IF/ID/EX/MEM/WB) in-order 32-bit DLX-subset integer CPU with private byte-wide IMEM/DMEM.
//  Top of the core; benches preload both memories hierarchically and inspect DMEM after halt.
//  Big-endian bit numbering [0:31]: bit 0 = MSB, opcode = [0:5].
// PARAMETERS
//  IMEM_SIZE  8192   instruction memory bytes (array imem_mem[0:IMEM_SIZE-1], 8-bit)
//  DMEM_SIZE  65536  data memory bytes (array dmem_mem[0:DMEM_SIZE-1], 8-bit)
// PORTS
//  clock   in   1   single clock; all state on rising edge
//  reset   in   1   asynchronous, active-high
//  pc      out  32  current fetch address
//  halted  out  1   high once TRAP 0x300 has retired; sticky until reset
// BEHAVIOUR
//  Encoding: R = op|rs1[6:10]|rs2[11:15]|rd[16:20]|func[26:31]; I = op|rs1|rd[11:15]|imm16[16:31];
//   J = op|off26[6:31]. Words big-endian in memory (addr = MSB byte); accesses word-aligned.
//  R (op 00) func: SLL 04, SRL 06, SRA 07 (shamt = rs2[27:31]), ADD 20, ADDU 21, SUB 22, SUBU 23,
//   AND 24, OR 25, XOR 26, SEQ 28, SNE 29, SLT 2A, SGT 2B, SLE 2C, SGE 2D (signed; result 0/1).
//  I ops: ADDI 08, ADDUI 09, SUBI 0A, SUBUI 0B (sign-ext imm); ANDI 0C, ORI 0D, XORI 0E (zero-ext);
//   LHI 0F (imm<<16); LW 23 rd=M[rs1+sext]; SW 2B M[rs1+sext]=rd; BEQZ 04, BNEZ 05 (test rs1);
//   J 02, JAL 03 (PC+4+sext26, JAL r31=PC+4); JR 12, JALR 13 (PC=rs1, JALR r31=PC+4); TRAP 11.
//  No overflow traps; unknown opcodes/funcs execute as NOP. r0 reads 0, writes ignored.
//  Reset (async): pc=0, halted=0, all 32 regs=0, every pipeline register = NOP (0x00000000),
//   no writes enabled. Memories not cleared. First fetch of addr 0 on first edge after release.
//  Latency: one instruction/cycle steady state; result written in WB, 4 edges after ID.
//  Register file: write-before-read in same cycle (WB value bypassed to ID read).
//  Forwarding to EX operands: from EX/MEM ALU result, else MEM/WB result (younger wins).
//  Branches/jumps resolve in ID (comparator + target adder in ID), NO delay slot: on taken, the
//   instruction in IF is squashed to NOP (1-cycle penalty); not-taken costs nothing.
//  ID-stage forwarding for branch/JR operands from EX/MEM ALU result and MEM/WB.
//  Stalls (hold PC and IF/ID, inject NOP into ID/EX):
//   - load-use: LW in EX and ID reads its rd -> 1 cycle.
//   - branch/JR operand produced by ALU op in EX -> 1 cycle; by LW in EX -> 2 cycles,
//     by LW in MEM -> 1 cycle.
//  Stall and taken branch same cycle: stall wins; branch re-evaluated next cycle.
//  SW data operand forwarded like EX operands (incl. load result from MEM/WB).
//  TRAP with imm 0x300 (word 0x44000300): when in ID, fetch freezes (pc holds, IF squashed);
//   older instructions drain; halted=1 the cycle TRAP reaches WB. Other TRAP imms = NOP.
//  Reset mid-run: immediate return to reset state; DMEM stores in flight are discarded.
// TESTING
//  Arith: ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; SW r3,0x2000(r0); TRAP 0x300 -> M[0x2000]=2, halted=1.
//  Forwarding: back-to-back ADDI r1,r0,1; ADD r1,r1,r1 x3; SW -> stored 8, no stall cycles.
//  Load-use: LW r4,0x2000(r0) (=7); ADD r5,r4,r4; SW -> 14 stored, exactly 1 bubble.
//  Branch: BNEZ loop summing 1..10 into r6, SW to 0x2004 -> 55; taken squashes IF (no delay slot).
//  JAL/JR call returns, r31 = call PC+4; SLT/SGE signed (-1<1 -> 1); SRA 0x80000000 by 4 -> 0xF8000000.
//  Reset asserted mid-loop -> pc=0, halted=0 asynchronously; program reruns to same result.

Source files
------------

// File: rtl/dlx_pipeline_if.sv
// dlx_pipeline_if: fetch address and halt status exported by the DLX core
interface dlx_pipeline_if;
   logic [31:0] pc;
   logic        halted;
   modport master (output pc, halted);
   modport slave  (input pc, halted);
endinterface

// File: rtl/dlx_pipeline.sv
// dlx_pipeline: five-stage in-order DLX-subset CPU with private byte-wide IMEM/DMEM
module dlx_pipeline #(
   parameter int IMEM_SIZE = 8192,
   parameter int DMEM_SIZE = 65536
) (
   input  logic           clock,
   input  logic           reset,
   dlx_pipeline_if.master bus
);
   localparam int IW = $clog2(IMEM_SIZE);
   localparam int DW = $clog2(DMEM_SIZE);
   localparam logic [31:0] HALT_WORD = 32'h4400_0300;

   logic [7:0]  imem_mem [0:IMEM_SIZE-1];
   logic [7:0]  dmem_mem [0:DMEM_SIZE-1];
   logic [31:0] regs [0:31];

   logic [31:0] pc, inst, if_ir, if_pc4;
   logic        fetch_stop, halted_q;
   logic [31:0] ie_ir, ie_pc4, ie_a, ie_b;
   logic [4:0]  ie_dest;
   logic        ie_we, ie_load, ie_store, ie_halt;
   logic [31:0] em_res, em_data;
   logic [4:0]  em_dest;
   logic        em_we, em_load, em_store, em_halt;
   logic [31:0] mw_res, ld_word;
   logic [4:0]  mw_dest;
   logic        mw_we, mw_halt;

   assign inst = {imem_mem[{pc[IW-1:2], 2'd0}], imem_mem[{pc[IW-1:2], 2'd1}],
                  imem_mem[{pc[IW-1:2], 2'd2}], imem_mem[{pc[IW-1:2], 2'd3}]};

   logic [5:0]  op, fn;
   logic [4:0]  s1, s2, dest;
   logic        r_ok, i_alu, lw, sw, br, jr, jmp, link, use1, use2, we, halt_id;
   logic        load_use, br_haz, stall, taken;
   logic [31:0] va, vb, target;

   assign op      = if_ir[31:26];
   assign fn      = if_ir[5:0];
   assign s1      = if_ir[25:21];
   assign s2      = if_ir[20:16];
   assign r_ok    = (op == 6'h00) && (fn inside {6'h04, 6'h06, 6'h07, [6'h20:6'h26], [6'h28:6'h2D]});
   assign i_alu   = op inside {[6'h08:6'h0F]};
   assign lw      = op == 6'h23;
   assign sw      = op == 6'h2B;
   assign br      = op == 6'h04 || op == 6'h05;
   assign jr      = op == 6'h12 || op == 6'h13;
   assign jmp     = op == 6'h02 || op == 6'h03;
   assign link    = op == 6'h03 || op == 6'h13;
   assign use1    = r_ok || (i_alu && op != 6'h0F) || lw || sw || br || jr;
   assign use2    = r_ok || sw;
   assign dest    = r_ok ? if_ir[15:11] : (i_alu || lw) ? s2 : link ? 5'd31 : 5'd0;
   assign we      = dest != 5'd0;
   assign halt_id = if_ir == HALT_WORD;

   // ID operand read: younger EX/MEM ALU result first, then MEM/WB (same as write-before-read)
   assign va = (em_we && !em_load && em_dest == s1) ? em_res : (mw_we && mw_dest == s1) ? mw_res : regs[s1];
   assign vb = (em_we && !em_load && em_dest == s2) ? em_res : (mw_we && mw_dest == s2) ? mw_res : regs[s2];

   // a load's data is not ready for EX next cycle; branches need operands finished one stage earlier
   assign load_use = ie_load && ((use1 && ie_dest == s1) || (use2 && ie_dest == s2));
   assign br_haz   = (br || jr) && ((ie_we && ie_dest == s1) || (em_load && em_dest == s1));
   assign stall    = load_use || br_haz;
   assign taken    = !stall && ((op == 6'h04 && va == '0) || (op == 6'h05 && va != '0) || jmp || jr);
   assign target   = jr ? va : if_pc4 + (jmp ? {{6{if_ir[25]}}, if_ir[25:0]} : {{16{if_ir[15]}}, if_ir[15:0]});

   // fetch and IF/ID: hold on stall, redirect and squash on taken, freeze for good once HALT decodes
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         pc         <= '0;
         if_ir      <= '0;
         if_pc4     <= '0;
         fetch_stop <= 1'b0;
      end else if (!stall) begin
         pc         <= taken ? target : (fetch_stop || halt_id) ? pc : pc + 32'd4;
         if_ir      <= (taken || fetch_stop || halt_id) ? '0 : inst;
         if_pc4     <= pc + 32'd4;
         fetch_stop <= fetch_stop || halt_id;
      end

   // ID/EX: a stall turns the issued slot into a bubble
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         ie_ir    <= '0;
         ie_pc4   <= '0;
         ie_a     <= '0;
         ie_b     <= '0;
         ie_dest  <= '0;
         ie_we    <= 1'b0;
         ie_load  <= 1'b0;
         ie_store <= 1'b0;
         ie_halt  <= 1'b0;
      end else begin
         ie_ir    <= stall ? '0 : if_ir;
         ie_pc4   <= if_pc4;
         ie_a     <= va;
         ie_b     <= vb;
         ie_dest  <= stall ? 5'd0 : dest;
         ie_we    <= !stall && we;
         ie_load  <= !stall && lw && we;
         ie_store <= !stall && sw;
         ie_halt  <= !stall && halt_id;
      end

   logic [5:0]  eop, efn;
   logic [4:0]  e1, e2;
   logic [31:0] ea, eb, sx, zx, alu;

   assign eop = ie_ir[31:26];
   assign efn = ie_ir[5:0];
   assign e1  = ie_ir[25:21];
   assign e2  = ie_ir[20:16];
   assign sx  = {{16{ie_ir[15]}}, ie_ir[15:0]};
   assign zx  = {16'h0000, ie_ir[15:0]};
   assign ea  = (em_we && !em_load && em_dest == e1) ? em_res : (mw_we && mw_dest == e1) ? mw_res : ie_a;
   assign eb  = (em_we && !em_load && em_dest == e2) ? em_res : (mw_we && mw_dest == e2) ? mw_res : ie_b;

   // EX ALU; link ops pass PC+4 through as their result
   always_comb begin
      alu = '0;
      if (eop == 6'h00)
         case (efn)
            6'h04:        alu = ea << eb[4:0];
            6'h06:        alu = ea >> eb[4:0];
            6'h07:        alu = $signed(ea) >>> eb[4:0];
            6'h20, 6'h21: alu = ea + eb;
            6'h22, 6'h23: alu = ea - eb;
            6'h24:        alu = ea & eb;
            6'h25:        alu = ea | eb;
            6'h26:        alu = ea ^ eb;
            6'h28:        alu = {31'd0, ea == eb};
            6'h29:        alu = {31'd0, ea != eb};
            6'h2A:        alu = {31'd0, $signed(ea) <  $signed(eb)};
            6'h2B:        alu = {31'd0, $signed(ea) >  $signed(eb)};
            6'h2C:        alu = {31'd0, $signed(ea) <= $signed(eb)};
            6'h2D:        alu = {31'd0, $signed(ea) >= $signed(eb)};
            default:      alu = '0;
         endcase
      else
         case (eop)
            6'h08, 6'h09, 6'h23, 6'h2B: alu = ea + sx;
            6'h0A, 6'h0B:               alu = ea - sx;
            6'h0C:                      alu = ea & zx;
            6'h0D:                      alu = ea | zx;
            6'h0E:                      alu = ea ^ zx;
            6'h0F:                      alu = {ie_ir[15:0], 16'h0000};
            6'h03, 6'h13:               alu = ie_pc4;
            default:                    alu = '0;
         endcase
   end

   // EX/MEM
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         em_res   <= '0;
         em_data  <= '0;
         em_dest  <= '0;
         em_we    <= 1'b0;
         em_load  <= 1'b0;
         em_store <= 1'b0;
         em_halt  <= 1'b0;
      end else begin
         em_res   <= alu;
         em_data  <= eb;
         em_dest  <= ie_dest;
         em_we    <= ie_we;
         em_load  <= ie_load;
         em_store <= ie_store;
         em_halt  <= ie_halt;
      end

   assign ld_word = {dmem_mem[{em_res[DW-1:2], 2'd0}], dmem_mem[{em_res[DW-1:2], 2'd1}],
                     dmem_mem[{em_res[DW-1:2], 2'd2}], dmem_mem[{em_res[DW-1:2], 2'd3}]};

   // DMEM store, big-endian; suppressed while reset is held so in-flight stores are dropped
   always_ff @(posedge clock)
      if (em_store && !reset) begin
         dmem_mem[{em_res[DW-1:2], 2'd0}] <= em_data[31:24];
         dmem_mem[{em_res[DW-1:2], 2'd1}] <= em_data[23:16];
         dmem_mem[{em_res[DW-1:2], 2'd2}] <= em_data[15:8];
         dmem_mem[{em_res[DW-1:2], 2'd3}] <= em_data[7:0];
      end

   // MEM/WB
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         mw_res  <= '0;
         mw_dest <= '0;
         mw_we   <= 1'b0;
         mw_halt <= 1'b0;
      end else begin
         mw_res  <= em_load ? ld_word : em_res;
         mw_dest <= em_dest;
         mw_we   <= em_we;
         mw_halt <= em_halt;
      end

   // register file write in WB and sticky halt flag
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
         halted_q <= 1'b0;
      end else begin
         if (mw_we) regs[mw_dest] <= mw_res;
         if (mw_halt) halted_q <= 1'b1;
      end

   assign bus.pc     = pc;
   assign bus.halted = halted_q || mw_halt;
endmodule

// File: tb/tb_dlx_pipeline.sv
// tb_dlx_pipeline: directed programs, scoreboard of expected stores/cycles checked at halt
module tb_dlx_pipeline;
   logic clock = 1'b0;
   logic reset = 1'b1;
   dlx_pipeline_if bus ();
   dlx_pipeline dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   typedef struct {
      int          prog;
      int          kind;
      logic [31:0] addr;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   tests = 0, fails = 0, cyc = 0, start = 0, prog = 0, la = 0;
   bit   done = 1'b1;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] rr(input logic [5:0] f, input logic [4:0] d, s, t);
      return {6'h00, s, t, d, 5'h00, f};
   endfunction
   function automatic logic [31:0] ii(input logic [5:0] o, input logic [4:0] d, s, input logic [15:0] imm);
      return {o, s, d, imm};
   endfunction
   function automatic logic [31:0] jj(input logic [5:0] o, input logic [25:0] off);
      return {o, off};
   endfunction
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {dut.dmem_mem[a], dut.dmem_mem[a+1], dut.dmem_mem[a+2], dut.dmem_mem[a+3]};
   endfunction

   task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, act, req);
      end
   endtask

   task automatic put(input logic [31:0] w);
      dut.imem_mem[la]   = w[31:24];
      dut.imem_mem[la+1] = w[23:16];
      dut.imem_mem[la+2] = w[15:8];
      dut.imem_mem[la+3] = w[7:0];
      la += 4;
   endtask

   task automatic expect_val(input string n, input int kind, input logic [31:0] addr, input logic [31:0] val);
      exp_t e;
      e.prog = prog; e.kind = kind; e.addr = addr; e.val = val; e.name = n;
      sb.push_back(e);
   endtask

   task automatic begin_prog(input int id);
      reset = 1'b1;
      @(negedge clock);
      prog = id;
      la = 0;
      for (int i = 0; i < 8192; i++) dut.imem_mem[i] = 8'h00;
      for (int i = 32'h2000; i < 32'h2040; i++) dut.dmem_mem[i] = 8'h00;
   endtask

   task automatic run();
      @(negedge clock);
      done  = 1'b0;
      reset = 1'b0;
      start = cyc;
      for (int i = 0; i < 2000 && !done; i++) @(negedge clock);
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL timeout: program %0d never halted", prog);
         while (sb.size() > 0 && sb[0].prog == prog) void'(sb.pop_front());
         done = 1'b1;
      end
   endtask

   task automatic load_loop();
      put(ii(6'h08, 5'd1, 5'd0, 16'd10));
      put(rr(6'h20, 5'd6, 5'd6, 5'd1));
      put(ii(6'h0A, 5'd1, 5'd1, 16'd1));
      put(ii(6'h05, 5'd0, 5'd1, 16'hFFF4));
      put(ii(6'h08, 5'd11, 5'd11, 16'd1));
      put(ii(6'h2B, 5'd6, 5'd0, 16'h2004));
      put(ii(6'h2B, 5'd11, 5'd0, 16'h2008));
      put(32'h4400_0300);
   endtask

   task automatic expect_loop();
      expect_val("loop_sum", 1, 32'h2004, 32'd55);
      expect_val("loop_fallthrough_count", 1, 32'h2008, 32'd1);
      expect_val("loop_cycles", 0, 0, 32'd57);
   endtask

   // monitor: on halt, retire every expectation queued for the running program
   initial forever begin
      exp_t        e;
      logic [31:0] act;
      @(negedge clock);
      if (!reset && bus.halted && !done) begin
         while (sb.size() > 0 && sb[0].prog == prog) begin
            e   = sb.pop_front();
            act = e.kind == 0 ? 32'(cyc - start) : e.kind == 1 ? mem_word(e.addr) : bus.pc;
            check(e.name, act, e.val);
         end
         done = 1'b1;
      end
   end

   initial begin
      repeat (3) @(negedge clock);
      check("reset_pc", bus.pc, 32'd0);
      check("reset_halted", {31'd0, bus.halted}, 32'd0);

      begin_prog(1);
      put(ii(6'h08, 5'd1, 5'd0, 16'd5));
      put(ii(6'h08, 5'd2, 5'd0, 16'hFFFD));
      put(rr(6'h20, 5'd3, 5'd1, 5'd2));
      put(ii(6'h2B, 5'd3, 5'd0, 16'h2000));
      put(32'h4400_0300);
      expect_val("arith_mem", 1, 32'h2000, 32'd2);
      expect_val("arith_cycles", 0, 0, 32'd8);
      expect_val("arith_pc_frozen", 2, 0, 32'd20);
      run();

      begin_prog(2);
      put(ii(6'h08, 5'd1, 5'd0, 16'd1));
      repeat (3) put(rr(6'h20, 5'd1, 5'd1, 5'd1));
      put(ii(6'h2B, 5'd1, 5'd0, 16'h2000));
      put(32'h4400_0300);
      expect_val("fwd_mem", 1, 32'h2000, 32'd8);
      expect_val("fwd_cycles", 0, 0, 32'd9);
      run();

      begin_prog(3);
      dut.dmem_mem[32'h2023] = 8'h07;
      put(ii(6'h23, 5'd4, 5'd0, 16'h2020));
      put(rr(6'h20, 5'd5, 5'd4, 5'd4));
      put(ii(6'h2B, 5'd5, 5'd0, 16'h2008));
      put(ii(6'h08, 5'd0, 5'd0, 16'd9));
      put(ii(6'h2B, 5'd0, 5'd0, 16'h200C));
      put(32'h4400_0300);
      expect_val("loaduse_mem", 1, 32'h2008, 32'd14);
      expect_val("r0_write_ignored", 1, 32'h200C, 32'd0);
      expect_val("loaduse_cycles", 0, 0, 32'd10);
      run();

      begin_prog(4);
      load_loop();
      expect_loop();
      run();

      begin_prog(5);
      put(ii(6'h08, 5'd1, 5'd0, 16'hFFFF));
      put(ii(6'h08, 5'd2, 5'd0, 16'd1));
      put(jj(6'h03, 26'd32));
      put(ii(6'h2B, 5'd31, 5'd0, 16'h2010));
      put(ii(6'h2B, 5'd3, 5'd0, 16'h2014));
      put(ii(6'h2B, 5'd4, 5'd0, 16'h2018));
      put(ii(6'h0F, 5'd7, 5'd0, 16'h8000));
      put(ii(6'h08, 5'd8, 5'd0, 16'd4));
      put(rr(6'h07, 5'd9, 5'd7, 5'd8));
      put(ii(6'h2B, 5'd9, 5'd0, 16'h201C));
      put(32'h4400_0300);
      put(rr(6'h2A, 5'd3, 5'd1, 5'd2));
      put(rr(6'h2D, 5'd4, 5'd2, 5'd1));
      put(ii(6'h12, 5'd0, 5'd31, 16'd0));
      expect_val("jal_link", 1, 32'h2010, 32'd12);
      expect_val("slt_signed", 1, 32'h2014, 32'd1);
      expect_val("sge_signed", 1, 32'h2018, 32'd1);
      expect_val("sra", 1, 32'h201C, 32'hF800_0000);
      run();

      begin_prog(6);
      load_loop();
      @(negedge clock);
      reset = 1'b0;
      repeat (20) @(negedge clock);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("midrst_pc", bus.pc, 32'd0);
      check("midrst_halted", {31'd0, bus.halted}, 32'd0);
      @(negedge clock);
      for (int i = 32'h2000; i < 32'h2040; i++) dut.dmem_mem[i] = 8'h00;
      expect_loop();
      run();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
